// File: rtl/cv32e40x_pkg.sv
// Shared types for the instruction aligner.
// Holds the aligner FSM encoding and the compressed-instruction test.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        ALIGNED    = 2'd0,
        RESIDUAL   = 2'd1,
        BRANCH_MIS = 2'd2
    } aligner_state_e;

    function automatic logic is_compressed(logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction

endpackage

// File: rtl/cv32e40x_instr_aligner.sv
// Instruction aligner: fetch words in, one whole instruction out per handshake.
// Define CV32E40X_ALIGNER_BUS_ERR_EN to propagate fetch bus errors.
module cv32e40x_instr_aligner
    import cv32e40x_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_err_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o,
    output logic        instr_bus_err_o
);

    aligner_state_e state_q, state_n, adv_state;
    logic [15:0]    res_q, res_n, adv_res;
    logic [31:0]    pc_q, pc_n;
    logic           armed_q;
    logic           err_q, err_n;
    logic           err_out;
    logic           word_err;
    logic           valid;
    logic           comp;
    logic           hs;

`ifdef CV32E40X_ALIGNER_BUS_ERR_EN
    assign word_err = fetch_valid_i && fetch_err_i;
`else
    logic unused_fetch_err;
    assign unused_fetch_err = fetch_err_i;
    assign word_err = 1'b0;
`endif

    always_comb begin
        state_n       = state_q;
        res_n         = res_q;
        pc_n          = pc_q;
        err_n         = err_q;
        adv_state     = state_q;
        adv_res       = res_q;
        valid         = 1'b0;
        comp          = 1'b0;
        err_out       = 1'b0;
        fetch_ready_o = 1'b0;
        instr_rdata_o = 32'h0;
        hs            = 1'b0;

        // Nothing leaves the aligner before the boot redirect arrives.
        if (armed_q && !branch_i) begin
            unique case (state_q)
                ALIGNED: begin
                    valid         = fetch_valid_i;
                    fetch_ready_o = instr_ready_i;
                    instr_rdata_o = fetch_rdata_i;
                    if (word_err) begin
                        err_out = 1'b1;
                    end else if (is_compressed(fetch_rdata_i[1:0])) begin
                        instr_rdata_o = {16'h0, fetch_rdata_i[15:0]};
                        comp          = 1'b1;
                        adv_res       = fetch_rdata_i[31:16];
                        adv_state     = RESIDUAL;
                    end
                end
                RESIDUAL: begin
                    if (is_compressed(res_q[1:0])) begin
                        valid         = 1'b1;
                        comp          = 1'b1;
                        instr_rdata_o = {16'h0, res_q};
                        adv_state     = ALIGNED;
                    end else begin
                        valid         = fetch_valid_i;
                        fetch_ready_o = instr_ready_i;
                        instr_rdata_o = {fetch_rdata_i[15:0], res_q};
                        if (word_err) begin
                            err_out   = 1'b1;
                            adv_res   = 16'h0;
                            adv_state = ALIGNED;
                        end else begin
                            adv_res = fetch_rdata_i[31:16];
                        end
                    end
                end
                BRANCH_MIS: begin
                    if (word_err) begin
                        valid         = 1'b1;
                        err_out       = 1'b1;
                        fetch_ready_o = instr_ready_i;
                        instr_rdata_o = fetch_rdata_i;
                        adv_res       = 16'h0;
                        adv_state     = ALIGNED;
                    end else begin
                        // Low half precedes the target: drop it, keep the upper.
                        fetch_ready_o = 1'b1;
                        if (fetch_valid_i) begin
                            res_n   = fetch_rdata_i[31:16];
                            state_n = RESIDUAL;
                        end
                    end
                end
                default: ;
            endcase

            hs = valid && instr_ready_i;
            if (hs) begin
                pc_n    = pc_q + (comp ? 32'd2 : 32'd4);
                res_n   = adv_res;
                state_n = adv_state;
                if (err_out) begin
                    err_n = 1'b1;
                end
            end
        end

        if (branch_i) begin
            pc_n    = branch_addr_i;
            res_n   = 16'h0;
            err_n   = 1'b0;
            state_n = branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALIGNED;
            res_q   <= 16'h0;
            pc_q    <= 32'h0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            res_q   <= res_n;
            pc_q    <= pc_n;
            err_q   <= err_n;
            if (branch_i) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign instr_valid_o      = valid;
    assign instr_compressed_o = comp;
    assign instr_pc_o         = pc_q;
    assign instr_bus_err_o    = err_q | err_out;

endmodule

// File: doc/cv32e40x_instr_aligner.md
# cv32e40x_instr_aligner

The instruction aligner sits between the prefetch buffer and the ID-stage decoder. It is the producer end of the decoder's instruction input. It takes 32-bit word-aligned fetch words and emits one complete instruction per handshake, each with its PC and a compressed flag. It buffers a 16-bit residual half-word so that it can reassemble 32-bit instructions that straddle word boundaries and pass through back-to-back compressed instructions.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  fetch word consumed this cycle
- fetch_rdata_i  in  32  word-aligned fetch data
- fetch_err_i  in  1  bus error on fetch word
- branch_i  in  1  PC redirect (flush)
- branch_addr_i  in  32  redirect target, bit0 = 0
- instr_valid_o  out  1  instruction valid to ID
- instr_ready_i  in  1  ID accepts instruction
- instr_rdata_o  out  32  instruction; compressed instructions are zero-extended half-words
- instr_pc_o  out  32  PC of instr_rdata_o
- instr_compressed_o  out  1  instr_rdata_o[1:0] != 2'b11
- instr_bus_err_o  out  1  instruction carries a fetch bus error

## Operation
- State is held in the FSM (ALIGNED, RESIDUAL, BRANCH_MIS), residual res_q[15:0], and pc_q[31:0].
- ALIGNED (no residual), with fetch_valid_i:
  - Low half is compressed: output it and load res_q with the upper half. On handshake, consume the word and go to RESIDUAL.
  - Low half is not compressed: output the full word. On handshake, consume the word.
- RESIDUAL, res_q compressed: output res_q without needing a fetch. fetch_ready_o=0. On handshake, go to ALIGNED.
- RESIDUAL, res_q is the low half of a 32-bit instruction: needs fetch_valid_i.
  - Output {fetch_rdata_i[15:0], res_q}.
  - On handshake: res_q <= fetch_rdata_i[31:16], consume the word, stay in RESIDUAL.
- BRANCH_MIS (branch to an address with bit1=1): on the first fetch_valid_i, consume the word, res_q <= fetch_rdata_i[31:16], go to RESIDUAL. No instruction is output in that cycle.
- A fetch word is consumed only when fetch_valid_i && fetch_ready_o.
- fetch_ready_o is combinational and depends on instr_ready_i.
- PC: pc_q += 2 after a compressed handshake, += 4 after a 32-bit handshake, with 32-bit wrap-around.
- Branch:
  - branch_i has priority over everything else.
  - Forces instr_valid_o=0 and fetch_ready_o=0.
  - Discards res_q.
  - pc_q <= branch_addr_i.
  - Next state is BRANCH_MIS if branch_addr_i[1] is set, else ALIGNED.
- Bus error (CV32E40X_ALIGNER_BUS_ERR_EN defined):
  - A word with fetch_err_i set is treated as a 32-bit instruction.
  - If no reassembly is pending, output it as-is with instr_bus_err_o=1.
  - If it completes a straddling instruction, the straddling instruction is flagged the same way.
  - On handshake, consume the word, clear the residual, and go to ALIGNED.
  - The flag stays set until the core branches.

## Timing
- Reset values: instr_valid_o=0, instr_bus_err_o=0, instr_compressed_o=0, fetch_ready_o=0, pc_q=0, state=ALIGNED, res_q=0.
- The first instruction fetch is always preceded by branch_i carrying the boot address.
- Latency:
  - ALIGNED and RESIDUAL-pass-through paths are combinational: 0 cycles from fetch_valid_i to instr_valid_o.
  - BRANCH_MIS adds one bubble cycle.
- Handshake: once instr_valid_o=1, instr_rdata_o, instr_pc_o and the flags stay stable until instr_ready_i or branch_i.
- A simultaneous branch_i and instr_ready_i drops the handshake: pc_q takes branch_addr_i.
- A compressed residual is output even while fetch_valid_i=0.
- Reset asserted mid-reassembly clears res_q immediately (asynchronous).

## Configuration
- CV32E40X_ALIGNER_BUS_ERR_EN defined: fetch_err_i is propagated as described under Operation.
- Undefined: fetch_err_i is ignored and instr_bus_err_o is tied 0. Error words are decoded as ordinary data.

## Structure
- cv32e40x_pkg holds:
  - aligner_state_e (ALIGNED, RESIDUAL, BRANCH_MIS).
  - A function is_compressed(logic [1:0]) returning whether the low bits differ from 2'b11.
- Single module. No sub-module is warranted: the datapath is a 2:1 half-word mux plus the PC incrementer.

## Test plan
- Branch to 0x100, word 0x00A00093 with ID always ready -> instr 0x00A00093, pc 0x100, compressed=0; next pc 0x104.
- Branch to 0x200, word 0x45014501 -> two instructions 0x00004501 at pc 0x200 and 0x202. fetch_ready_o=0 during the second.
- Branch to 0x302, word 0x00934501, then 0x000000A0 -> bubble, then 32-bit 0x00A00093 at pc 0x302; res_q=0x0000 remains.
- instr_ready_i held low 3 cycles with a valid instruction -> outputs stable, no fetch consumed; branch_i on cycle 2 -> valid drops, pc=branch target.
- With the macro defined, fetch_err_i=1 on the second word of a straddling instruction -> instr_bus_err_o=1, state ALIGNED. Without the macro -> instr_bus_err_o=0.
- rst_n asserted while in RESIDUAL -> all outputs at reset values in the same cycle; no instruction output until branch_i.
